ps2_host_ctrl: RTL and testbench

PS2_HOST_CTRL -- requirements
Module: ps2_host_ctrl

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_fifo.sv | 69 ++++++
 rtl/ps2_host_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ps2_host_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 host types and timing defaults.
package ps2_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_INHIBIT,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP,
    TX_ACK,
    TX_DONE
  } tx_state_e;

  // 100 us inhibit and 15 ms transmit window at 50 MHz
  localparam int INHIBIT_CYC_DEF = 5000;
  localparam int TIMEOUT_CYC_DEF = 750000;

endpackage

// File: rtl/ps2_fifo.sv
// Receive scancode FIFO with separate occupancy count and sticky overflow.
module ps2_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  input  logic             ovf_clr_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             ovf_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             full, do_push, do_pop, drop;

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push_i & (~full | do_pop);
  assign drop    = push_i & full & ~do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (drop)           ovf_d = 1'b1;
    else if (ovf_clr_i) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 host: scancode receive FIFO plus optional host-to-device transmitter.
// Define PS2_HOST_TX_EN to build the transmit FSM; otherwise the block is receive-only.
module ps2_host_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int INHIBIT_CYC = INHIBIT_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_code,
  input  logic       rx_irq,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_empty,
  output logic       ovf,
  input  logic       ovf_clr,
  input  logic       tx_req,
  input  logic [7:0] tx_byte,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps_clk_in,
  input  logic       ps_data_in,
  output logic       ps_clk_oe,
  output logic       ps_data_oe
);

  logic rx_irq_q, rx_en, push;

  always_ff @(posedge clk) begin
    if (rst) rx_irq_q <= 1'b0;
    else     rx_irq_q <= rx_irq;
  end

  assign push = rx_irq & ~rx_irq_q & rx_en;

  ps2_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .din_i     (rx_code),
    .pop_i     (rd_en),
    .ovf_clr_i (ovf_clr),
    .dout_o    (rd_data),
    .empty_o   (rd_empty),
    .ovf_o     (ovf)
  );

`ifdef PS2_HOST_TX_EN
  localparam int IW = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC + 1) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  tx_state_e     state_q, state_d;
  logic [7:0]    byte_q, byte_d;
  logic [2:0]    bit_q, bit_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [TW-1:0] to_q, to_d;
  logic          err_q, err_d;
  logic          clk_prev_q, fall;
  logic          clk_oe_c, data_oe_c;

  assign fall = clk_prev_q & ~ps_clk_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      byte_q     <= '0;
      bit_q      <= '0;
      inh_q      <= '0;
      to_q       <= '0;
      err_q      <= 1'b0;
      clk_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      bit_q      <= bit_d;
      inh_q      <= inh_d;
      to_q       <= to_d;
      err_q      <= err_d;
      clk_prev_q <= ps_clk_in;
    end
  end

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    bit_d     = bit_q;
    inh_d     = inh_q;
    to_d      = to_q;
    err_d     = err_q;
    clk_oe_c  = 1'b0;
    data_oe_c = 1'b0;
    case (state_q)
      TX_IDLE: if (tx_req) begin
        byte_d  = tx_byte;
        inh_d   = '0;
        err_d   = 1'b0;
        state_d = TX_INHIBIT;
      end
      TX_INHIBIT: begin
        clk_oe_c = 1'b1;
        if (inh_q == IW'(INHIBIT_CYC - 1)) begin
          data_oe_c = 1'b1;
          to_d      = '0;
          state_d   = TX_START;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      TX_START: begin
        data_oe_c = 1'b1;
        if (fall) begin
          bit_d   = '0;
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        data_oe_c = ~byte_q[bit_q];
        if (fall) begin
          if (bit_q == 3'd7) state_d = TX_PARITY;
          else               bit_d   = bit_q + 1'b1;
        end
      end
      // odd parity bit is ~^byte, so the line is pulled low when ^byte is 1
      TX_PARITY: begin
        data_oe_c = ^byte_q;
        if (fall) state_d = TX_STOP;
      end
      TX_STOP: if (fall) state_d = TX_ACK;
      TX_ACK: if (fall) begin
        err_d   = ps_data_in;
        state_d = TX_DONE;
      end
      TX_DONE: state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase
    if (state_q inside {TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_ACK}) begin
      if (to_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = TX_DONE;
        err_d   = 1'b1;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
  end

  assign rx_en      = (state_q == TX_IDLE) || (state_q == TX_DONE);
  assign tx_busy    = (state_q != TX_IDLE);
  assign tx_done    = (state_q == TX_DONE);
  assign tx_err     = tx_done & err_q;
  assign ps_clk_oe  = clk_oe_c;
  assign ps_data_oe = data_oe_c;
`else
  logic unused_tx;
  localparam int UNUSED_CYC = INHIBIT_CYC + TIMEOUT_CYC;
  assign unused_tx  = ^{tx_req, tx_byte, ps_clk_in, ps_data_in, UNUSED_CYC[0]};
  assign rx_en      = 1'b1;
  assign tx_busy    = 1'b0;
  assign tx_done    = 1'b0;
  assign tx_err     = 1'b0;
  assign ps_clk_oe  = 1'b0;
  assign ps_data_oe = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Self-checking bench: FIFO scoreboard plus PS/2 device model for the transmitter.
module tb_ps2_host_ctrl;

  localparam int DEPTH = 8;
  localparam int INH   = 5000;
  localparam int TMO   = 10000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_code = '0;
  logic       rx_irq = 1'b0, rd_en = 1'b0, ovf_clr = 1'b0, tx_req = 1'b0;
  logic [7:0] tx_byte = '0;
  logic [7:0] rd_data;
  logic       rd_empty, ovf, tx_busy, tx_done, tx_err, ps_clk_oe, ps_data_oe;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       ps_clk_in, ps_data_in;

  always #5 clk = ~clk;

  // open-collector bus: either side may pull low
  assign ps_clk_in  = ~ps_clk_oe & dev_clk;
  assign ps_data_in = ~ps_data_oe & dev_data;

  ps2_host_ctrl #(.FIFO_DEPTH(DEPTH), .INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rx_code(rx_code), .rx_irq(rx_irq), .rd_en(rd_en),
    .rd_data(rd_data), .rd_empty(rd_empty), .ovf(ovf), .ovf_clr(ovf_clr),
    .tx_req(tx_req), .tx_byte(tx_byte), .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_err(tx_err), .ps_clk_in(ps_clk_in), .ps_data_in(ps_data_in),
    .ps_clk_oe(ps_clk_oe), .ps_data_oe(ps_data_oe)
  );

  int         n_chk = 0, n_pass = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;
  logic       done_q[$];

  always @(negedge clk) if (tx_done === 1'b1) done_q.push_back(tx_err);

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(logic [7:0] code, int len, logic rd, logic clr);
    logic pop, drop;
    rx_code = code; rx_irq = 1'b1; rd_en = rd; ovf_clr = clr;
    pop = rd && exp_q.size() > 0;
    if (pop) chk("strobe_rd_data", rd_data, exp_q.pop_front());
    drop = !pop && exp_q.size() == DEPTH;
    if (!drop) exp_q.push_back(code);
    if (drop) exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
    tick();
    rd_en = 1'b0; ovf_clr = 1'b0;
    chk("ovf", ovf, exp_ovf);
    chk("empty_after_push", rd_empty, exp_q.size() == 0);
    chk("head_after_push", rd_data, exp_q.size() > 0 ? exp_q[0] : 8'h00);
    if (len > 1) tick(len - 1);
    rx_irq = 1'b0;
    tick(2);
  endtask

  task automatic pop_chk();
    if (exp_q.size() == 0) begin
      chk("empty_before_rd", rd_empty, 1);
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      chk("empty_rd_ignored", rd_empty, 1);
    end else begin
      chk("rd_data", rd_data, exp_q.pop_front());
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      chk("rd_empty", rd_empty, exp_q.size() == 0);
    end
  endtask

  task automatic wait_done(string tag, logic exp_err, int limit);
    int w = 0;
    while (done_q.size() == 0 && w < limit) begin tick(); w++; end
    if (done_q.size() == 0) chk({tag, "_done_seen"}, 0, 1);
    else chk({tag, "_err"}, done_q.pop_front(), exp_err);
    tick();
    chk({tag, "_busy_after"}, tx_busy, 0);
    chk({tag, "_clk_oe_after"}, ps_clk_oe, 0);
    chk({tag, "_data_oe_after"}, ps_data_oe, 0);
  endtask

`ifdef PS2_HOST_TX_EN
  task automatic wait_inhibit(output int hi, output logic d_last, input bit rx_during);
    hi = 0; d_last = 1'b0;
    while (ps_clk_oe && hi < INH + 10) begin
      hi++;
      d_last = ps_data_oe;
      if (rx_during && hi == 10) begin rx_code = 8'h77; rx_irq = 1'b1; end
      if (rx_during && hi == 12) rx_irq = 1'b0;
      tick();
    end
  endtask

  task automatic do_tx(logic [7:0] b, logic ack, bit rx_during);
    int         hi;
    logic       d_last, par, stp;
    logic [7:0] got;
    got = '0; par = 1'b0; stp = 1'b0;
    tx_byte = b; tx_req = 1'b1; tick(); tx_req = 1'b0; tx_byte = 8'h00;
    chk("tx_busy", tx_busy, 1);
    wait_inhibit(hi, d_last, rx_during);
    chk("inhibit_len", hi, INH);
    chk("inhibit_last_data_oe", d_last, 1);
    chk("start_bit", ps_data_in, 0);
    for (int k = 0; k < 11; k++) begin
      if (k == 10) dev_data = ack;
      dev_clk = 1'b0; tick(4);
      if (k < 8)       got[k] = ps_data_in;
      else if (k == 8) par = ps_data_in;
      else if (k == 9) stp = ps_data_in;
      dev_clk = 1'b1; tick(4);
    end
    dev_data = 1'b1;
    chk("tx_bits", got, b);
    chk("tx_parity", par, ~^b);
    chk("tx_stop", stp, 1);
    wait_done("tx", ack, 50);
  endtask
`endif

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("rst_rd_empty", rd_empty, 1);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_ovf", ovf, 0);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_tx_err", tx_err, 0);
    chk("rst_clk_oe", ps_clk_oe, 0);
    chk("rst_data_oe", ps_data_oe, 0);
    rst = 1'b0;
    tick();

    // single 4-cycle strobe, then an extra read against an empty FIFO
    strobe(8'h1C, 4, 1'b0, 1'b0);
    pop_chk();
    pop_chk();

    // nine strobes into eight slots
    for (int i = 0; i < 9; i++) strobe(8'h10 + 8'(i), (i % 4) + 1, 1'b0, 1'b0);
    chk("ovf_after_9", ovf, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0; exp_ovf = 1'b0;
    chk("ovf_cleared", ovf, 0);

    // full: push+pop together succeeds; drop with clear in same cycle keeps ovf
    strobe(8'hA5, 2, 1'b1, 1'b0);
    strobe(8'hB6, 1, 1'b0, 1'b1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0; exp_ovf = 1'b0;
    chk("ovf_cleared2", ovf, 0);
    repeat (DEPTH) pop_chk();
    pop_chk();

    // pointers wrapped past the end of storage
    for (int i = 0; i < 3; i++) strobe(8'hC0 + 8'(i), 1, 1'b0, 1'b0);
    repeat (3) pop_chk();

`ifdef PS2_HOST_TX_EN
    do_tx(8'hED, 1'b0, 1'b0);
    do_tx(8'hED, 1'b1, 1'b1);
    pop_chk();

    // device never clocks
    tx_byte = 8'h42; tx_req = 1'b1; tick(); tx_req = 1'b0;
    wait_done("timeout", 1'b1, INH + TMO + 50);

    // reset in the middle of the data bits
    begin
      int   hi;
      logic d_last;
      tx_byte = 8'h3C; tx_req = 1'b1; tick(); tx_req = 1'b0;
      wait_inhibit(hi, d_last, 1'b0);
      for (int k = 0; k < 3; k++) begin
        dev_clk = 1'b0; tick(4); dev_clk = 1'b1; tick(4);
      end
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst_mid_clk_oe", ps_clk_oe, 0);
      chk("rst_mid_data_oe", ps_data_oe, 0);
      chk("rst_mid_busy", tx_busy, 0);
      tick(20);
      chk("rst_mid_no_done", done_q.size(), 0);
    end
    do_tx(8'h5A, 1'b0, 1'b0);
`else
    tx_byte = 8'hED; tx_req = 1'b1; tick(); tx_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rxonly_busy", tx_busy, 0);
      chk("rxonly_clk_oe", ps_clk_oe, 0);
      chk("rxonly_data_oe", ps_data_oe, 0);
      tick();
    end
    chk("rxonly_no_done", done_q.size(), 0);
    strobe(8'h66, 2, 1'b0, 1'b0);
    pop_chk();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
